mgt_01_mul_sequencer: RTL

//  Sequences MGT_01_multiply_unit between the issue stage and writeback. Accepts
//  one MUL/MULH/MULHSU/MULHU op at a time over a valid/ready handshake and holds

---
 rtl/mgt_01_mul_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mgt_01_mul_sequencer.sv
// Issue-to-writeback sequencer for the iterative Booth multiply unit: holds one op,
// clock-gates the unit for exactly one pass, and presents the captured result to writeback.
package Modules_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {
    MUL_    = 2'd0,
    MULH_   = 2'd1,
    MULHSU_ = 2'd2,
    MULHU_  = 2'd3
  } mul_ops_e;
endpackage

module mgt_01_mul_sequencer #(
  parameter int XLEN    = Modules_pkg::XLEN,
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  Modules_pkg::mul_ops_e issue_op_i,
  input  logic [XLEN-1:0]       issue_a_i,
  input  logic [XLEN-1:0]       issue_b_i,
  input  logic [TAG_W-1:0]      issue_tag_i,
  input  logic                  flush_i,
  output logic [XLEN-1:0]       mul_multiplier_o,
  output logic [XLEN-1:0]       mul_multiplicand_o,
  output Modules_pkg::mul_ops_e mul_op_o,
  output logic                  mul_clk_en_o,
  input  logic                  mul_free_i,
  input  logic [XLEN-1:0]       mul_result_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [XLEN-1:0]       wb_result_o,
  output logic [TAG_W-1:0]      wb_tag_o,
  output logic                  busy_o,
  output logic                  timeout_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, START, BUSY, DONE, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [XLEN-1:0]       operandA_q, operandA_d;
  logic [XLEN-1:0]       operandB_q, operandB_d;
  logic [XLEN-1:0]       result_q, result_d;
  Modules_pkg::mul_ops_e opCode_q, opCode_d;
  logic [TAG_W-1:0]      destTag_q, destTag_d;
  logic [CNT_W-1:0]      busyCnt_q, busyCnt_d;
  logic                  timeoutErr_q, timeoutErr_d;
  logic                  issueReady;
  logic                  accept;
  logic                  clkEn;
  logic                  cntExpired;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      operandA_q   <= '0;
      operandB_q   <= '0;
      result_q     <= '0;
      opCode_q     <= Modules_pkg::MUL_;
      destTag_q    <= '0;
      busyCnt_q    <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      operandA_q   <= operandA_d;
      operandB_q   <= operandB_d;
      result_q     <= result_d;
      opCode_q     <= opCode_d;
      destTag_q    <= destTag_d;
      busyCnt_q    <= busyCnt_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  assign cntExpired = (busyCnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    operandA_d   = operandA_q;
    operandB_d   = operandB_q;
    result_d     = result_q;
    opCode_d     = opCode_q;
    destTag_d    = destTag_q;
    busyCnt_d    = busyCnt_q;
    timeoutErr_d = timeoutErr_q;
    clkEn        = 1'b0;

    issueReady = !flush_i && ((state_q == IDLE) || ((state_q == DONE) && wb_ready_i));
    accept     = issue_valid_i && issueReady;

    // Operands feed the unit's combinational output mux, so they move only on accept.
    if (accept) begin
      operandA_d = issue_a_i;
      operandB_d = issue_b_i;
      opCode_d   = issue_op_i;
      destTag_d  = issue_tag_i;
      busyCnt_d  = '0;
    end

    case (state_q)
      IDLE: begin
        if (accept) state_d = START;
      end
      START: begin
        clkEn   = 1'b1;
        state_d = flush_i ? DRAIN : BUSY;
      end
      BUSY: begin
        clkEn = !mul_free_i;
        if (mul_free_i && !flush_i) begin
          result_d = mul_result_i;
          state_d  = DONE;
        end else if (!mul_free_i && cntExpired) begin
          timeoutErr_d = 1'b1;
          state_d      = IDLE;
        end else begin
          busyCnt_d = busyCnt_q + CNT_W'(1);
          if (flush_i) state_d = DRAIN;
        end
      end
      DONE: begin
        if (flush_i) state_d = IDLE;
        else if (wb_ready_i) state_d = accept ? START : IDLE;
      end
      DRAIN: begin
        // The unit cannot be aborted, so let it finish its pass and discard the result.
        clkEn = !mul_free_i;
        if (mul_free_i) begin
          state_d = IDLE;
        end else if (cntExpired) begin
          timeoutErr_d = 1'b1;
          state_d      = IDLE;
        end else begin
          busyCnt_d = busyCnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign issue_ready_o      = issueReady;
  assign mul_multiplier_o   = operandA_q;
  assign mul_multiplicand_o = operandB_q;
  assign mul_op_o           = opCode_q;
  assign mul_clk_en_o       = clkEn;
  assign wb_valid_o         = (state_q == DONE);
  assign wb_result_o        = result_q;
  assign wb_tag_o           = destTag_q;
  assign busy_o             = (state_q != IDLE);
  assign timeout_err_o      = timeoutErr_q;

  startNeedsFreeUnit: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (state_q == START) |-> mul_free_i);

endmodule
